// File: rtl/gt_link_init_monitor_if.sv
// Status and reset-request signals between a GT channel's reset controller and
// the bring-up monitor. The monitor uses the master side.
interface gt_link_init_monitor_if;
   logic       gtwiz_reset_tx_done_in;
   logic       gtwiz_reset_rx_done_in;
   logic       prbs_match_in;
   logic       link_down_latched_reset_in;
   logic       reset_all_init_out;
   logic       reset_rx_init_out;
   logic       init_done_out;
   logic [3:0] init_retry_ctr_out;
   logic       link_status_out;
   logic       link_down_latched_out;

   modport master (
      input  gtwiz_reset_tx_done_in,
      input  gtwiz_reset_rx_done_in,
      input  prbs_match_in,
      input  link_down_latched_reset_in,
      output reset_all_init_out,
      output reset_rx_init_out,
      output init_done_out,
      output init_retry_ctr_out,
      output link_status_out,
      output link_down_latched_out
   );

   modport slave (
      output gtwiz_reset_tx_done_in,
      output gtwiz_reset_rx_done_in,
      output prbs_match_in,
      output link_down_latched_reset_in,
      input  reset_all_init_out,
      input  reset_rx_init_out,
      input  init_done_out,
      input  init_retry_ctr_out,
      input  link_status_out,
      input  link_down_latched_out
   );
endinterface

// File: rtl/gt_link_init_monitor.sv
// Bring-up supervisor for one GT channel: waits for TX/RX reset done, qualifies
// link-up from PRBS match, and reissues reset requests on timeout or link loss.
module gt_link_init_monitor #(
   parameter logic [23:0] P_TX_TIMEOUT  = 24'd1250000,
   parameter logic [23:0] P_RX_TIMEOUT  = 24'd1250000,
   parameter int unsigned P_PULSE_LEN   = 32'd8,
   parameter int unsigned P_GUARD       = 32'd16,
   parameter int unsigned P_LINK_UP_CNT = 32'd128
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   gt_link_init_monitor_if.master bus
);

   typedef enum logic [2:0] {
      ST_START     = 3'd0,
      ST_TX_WAIT   = 3'd1,
      ST_RX_WAIT   = 3'd2,
      ST_MONITOR   = 3'd3,
      ST_RESET_ALL = 3'd4,
      ST_RESET_RX  = 3'd5
   } state_e;

   localparam logic [23:0] TX_LAST    = P_TX_TIMEOUT - 24'd1;
   localparam logic [23:0] RX_LAST    = P_RX_TIMEOUT - 24'd1;
   localparam logic [23:0] PULSE_LAST = 24'(P_PULSE_LEN - 32'd1);
   localparam logic [23:0] GUARD      = 24'(P_GUARD);
   localparam logic [15:0] LINK_MAX   = 16'(P_LINK_UP_CNT);

   logic       tx_done_s;
   logic       rx_done_s;
   logic       match_s;
   logic       ld_reset_s;

   state_e     state_r;
   state_e     state_s;
   logic [23:0] timer_r;
   logic [23:0] timer_s;
   logic [15:0] link_cnt_r;
   logic [15:0] link_cnt_s;
   logic        link_up_s;
   logic        link_status_r;
   logic        link_down_r;
   logic        link_down_s;
   logic [3:0]  retry_r;
   logic [3:0]  retry_s;
   logic        reset_all_r;
   logic        reset_rx_r;
   logic        init_done_r;

   assign tx_done_s  = bus.gtwiz_reset_tx_done_in;
   assign rx_done_s  = bus.gtwiz_reset_rx_done_in;
   assign match_s    = bus.prbs_match_in;
   assign ld_reset_s = bus.link_down_latched_reset_in;

   // Link qualifier: run of consecutive match cycles with RX done, saturating
   always_comb begin
      link_cnt_s = 16'd0;
      if (rx_done_s && match_s) begin
         if (link_cnt_r >= LINK_MAX) begin
            link_cnt_s = LINK_MAX;
         end else begin
            link_cnt_s = link_cnt_r + 16'd1;
         end
      end else begin
         link_cnt_s = 16'd0;
      end
   end

   // Status uses the next count so link-up lands on the LINK_MAX-th qualifying edge
   assign link_up_s = (link_cnt_s == LINK_MAX);

   // Sticky link-loss flag; a falling link wins over a simultaneous clear
   always_comb begin
      link_down_s = link_down_r;
      if (link_status_r && !link_up_s) begin
         link_down_s = 1'b1;
      end else if (ld_reset_s) begin
         link_down_s = 1'b0;
      end else begin
         link_down_s = link_down_r;
      end
   end

   // Next-state logic; MONITOR checks full-reset causes before link loss
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_START: begin
            state_s = ST_TX_WAIT;
         end
         ST_TX_WAIT: begin
            if ((timer_r >= GUARD) && tx_done_s) begin
               state_s = ST_RX_WAIT;
            end else if (timer_r == TX_LAST) begin
               state_s = ST_RESET_ALL;
            end else begin
               state_s = ST_TX_WAIT;
            end
         end
         ST_RX_WAIT: begin
            if ((timer_r >= GUARD) && rx_done_s && link_status_r) begin
               state_s = ST_MONITOR;
            end else if (timer_r == RX_LAST) begin
               state_s = ST_RESET_RX;
            end else begin
               state_s = ST_RX_WAIT;
            end
         end
         ST_MONITOR: begin
            if (!tx_done_s || !rx_done_s) begin
               state_s = ST_RESET_ALL;
            end else if (!link_status_r) begin
               state_s = ST_RESET_RX;
            end else begin
               state_s = ST_MONITOR;
            end
         end
         ST_RESET_ALL: begin
            if (timer_r == PULSE_LAST) begin
               state_s = ST_TX_WAIT;
            end else begin
               state_s = ST_RESET_ALL;
            end
         end
         ST_RESET_RX: begin
            if (timer_r == PULSE_LAST) begin
               state_s = ST_RX_WAIT;
            end else begin
               state_s = ST_RESET_RX;
            end
         end
         default: begin
            state_s = ST_START;
         end
      endcase
   end

   // Timer restarts on every state change, so pulse cycles never eat into a wait
   always_comb begin
      timer_s = 24'd0;
      if (state_s != state_r) begin
         timer_s = 24'd0;
      end else if ((state_r == ST_START) || (state_r == ST_MONITOR)) begin
         timer_s = 24'd0;
      end else if (timer_r == 24'hFF_FFFF) begin
         timer_s = timer_r;
      end else begin
         timer_s = timer_r + 24'd1;
      end
   end

   // Retry count bumps once per entry into either reset state, saturating at 15
   always_comb begin
      retry_s = retry_r;
      if ((state_s != state_r) &&
          ((state_s == ST_RESET_ALL) || (state_s == ST_RESET_RX)) &&
          (retry_r != 4'hF)) begin
         retry_s = retry_r + 4'd1;
      end else begin
         retry_s = retry_r;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r       <= ST_START;
         timer_r       <= 24'd0;
         link_cnt_r    <= 16'd0;
         link_status_r <= 1'b0;
         link_down_r   <= 1'b1;
         retry_r       <= 4'd0;
         reset_all_r   <= 1'b0;
         reset_rx_r    <= 1'b0;
         init_done_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         timer_r       <= timer_s;
         link_cnt_r    <= link_cnt_s;
         link_status_r <= link_up_s;
         link_down_r   <= link_down_s;
         retry_r       <= retry_s;
         reset_all_r   <= (state_s == ST_RESET_ALL);
         reset_rx_r    <= (state_s == ST_RESET_RX);
         init_done_r   <= (state_s == ST_MONITOR);
      end
   end

   assign bus.reset_all_init_out    = reset_all_r;
   assign bus.reset_rx_init_out     = reset_rx_r;
   assign bus.init_done_out         = init_done_r;
   assign bus.init_retry_ctr_out    = retry_r;
   assign bus.link_status_out       = link_status_r;
   assign bus.link_down_latched_out = link_down_r;

endmodule
